// File: rtl/signed_shift_accum.sv
// Purpose: accumulates signed, segment-shifted LUT patterns into a wide two's-complement group sum.
// Latency: the result is valid on the cycle after the in_last term is accepted.
// Backpressure: the result is held until out_ready. in_ready is low while a result is held (one dead cycle per group).
module signed_shift_accum #(
    parameter int ACC_W    = 72,
    parameter int SEG_W    = 3,
    parameter int SEG_STEP = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [SEG_W-1:0] in_seg,
    input  logic [8:0]       in_pattern,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    // Wide enough to hold the pattern at the largest segment offset, so truncated bits stay visible.
    localparam int WIDE_W = ACC_W + 9 + ((1 << SEG_W) - 1) * SEG_STEP;

    typedef enum logic [1:0] {S_EMPTY, S_ACCUM, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_in_rdy;
    logic               w_accept;

    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_out_vld;
    logic [ACC_W-1:0]   r_out_sum;
    logic [CNT_W-1:0]   r_out_cnt;
    logic               r_out_ovf;

    logic [31:0]        w_shamt;
    logic [WIDE_W-1:0]  w_wide;
    logic [ACC_W-1:0]   w_term;
    logic               w_trunc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               w_sgn_ovf;
    logic               w_term_ovf;
    logic [CNT_W-1:0]   w_cnt_nxt;

    assign w_accept = in_valid & w_in_rdy;

    // Term formation and signed add/sub, with the overflow judged on the ACC_W-bit operands.
    always_comb begin
        w_shamt    = 32'(in_seg) * 32'(SEG_STEP);
        w_wide     = WIDE_W'(in_pattern) << w_shamt;
        w_term     = w_wide[ACC_W-1:0];
        w_trunc    = |w_wide[WIDE_W-1:ACC_W];
        w_acc_nxt  = in_sign ? (r_acc - w_term) : (r_acc + w_term);
        if (in_sign) begin
            w_sgn_ovf = (r_acc[ACC_W-1] != w_term[ACC_W-1]) && (w_acc_nxt[ACC_W-1] != r_acc[ACC_W-1]);
        end else begin
            w_sgn_ovf = (r_acc[ACC_W-1] == w_term[ACC_W-1]) && (w_acc_nxt[ACC_W-1] != r_acc[ACC_W-1]);
        end
        w_term_ovf = w_trunc | w_sgn_ovf;
        w_cnt_nxt  = (&r_cnt) ? r_cnt : (r_cnt + 1'b1);
    end

    // Next-state and in_ready decode. in_ready depends only on the state, never on out_ready.
    always_comb begin
        w_state_nxt = r_state;
        w_in_rdy    = 1'b0;
        case (r_state)
            S_EMPTY, S_ACCUM: begin
                w_in_rdy = 1'b1;
                if (w_accept) begin
                    w_state_nxt = in_last ? S_DRAIN : S_ACCUM;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulator, counter and sticky overflow. The result is captured and the group state is cleared on the last term.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_out_vld <= 1'b0;
            r_out_sum <= '0;
            r_out_cnt <= '0;
            r_out_ovf <= 1'b0;
        end else begin
            if (w_accept) begin
                if (in_last) begin
                    r_out_sum <= w_acc_nxt;
                    r_out_cnt <= w_cnt_nxt;
                    r_out_ovf <= r_ovf | w_term_ovf;
                    r_out_vld <= 1'b1;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_ovf     <= 1'b0;
                end else begin
                    r_acc     <= w_acc_nxt;
                    r_cnt     <= w_cnt_nxt;
                    r_ovf     <= r_ovf | w_term_ovf;
                end
            end
            if ((r_state == S_DRAIN) && out_ready) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign in_ready     = w_in_rdy;
    assign out_valid    = r_out_vld;
    assign out_sum      = r_out_sum;
    assign out_count    = r_out_cnt;
    assign out_overflow = r_out_ovf;

endmodule

// File: tb/tb_signed_shift_accum.sv
// Purpose: directed self-checking bench for signed_shift_accum (ACC_W=64 to expose truncation, CNT_W=4 to reach saturation).
// Latency: checks sample #1 after the rising edge. The result is expected on the edge after the last term is accepted.
// Backpressure: exercises held results, ignored input while draining, and the dead cycle after drain.
module tb_signed_shift_accum;

    localparam int ACC_W = 64;
    localparam int SEG_W = 3;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [SEG_W-1:0] in_seg;
    logic [8:0]       in_pattern;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    signed_shift_accum #(
        .ACC_W(ACC_W), .SEG_W(SEG_W), .SEG_STEP(8), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
        .in_seg(in_seg), .in_pattern(in_pattern), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .out_overflow(out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at posedge+1. Presents one term and waits (bounded) for it to be accepted.
    task automatic send(input logic s, input logic [SEG_W-1:0] sg, input logic [8:0] p, input logic l);
        int n;
        in_sign = s; in_seg = sg; in_pattern = p; in_last = l; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_tests++;
        if (n >= 20) begin
            $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
            n_fail++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Called at posedge+1 while a result is pending. Accepts it in one cycle.
    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_tests += 5;
        if (out_valid !== 1'b0)    begin $display("FAIL reset_out_valid got %0b want 0", out_valid); n_fail++; end
        if (in_ready !== 1'b1)     begin $display("FAIL reset_in_ready got %0b want 1", in_ready); n_fail++; end
        if (out_sum !== '0)        begin $display("FAIL reset_out_sum got %0h want 0", out_sum); n_fail++; end
        if (out_count !== '0)      begin $display("FAIL reset_out_count got %0d want 0", out_count); n_fail++; end
        if (out_overflow !== 1'b0) begin $display("FAIL reset_out_overflow got %0b want 0", out_overflow); n_fail++; end
    endtask

    task automatic test_single();
        send(1'b0, 3'd0, 9'h010, 1'b1);
        n_tests += 7;
        if (out_valid !== 1'b1)     begin $display("FAIL single_valid got %0b want 1", out_valid); n_fail++; end
        if (out_sum !== 64'd16)     begin $display("FAIL single_sum got %0d want 16", out_sum); n_fail++; end
        if (out_count !== 4'd1)     begin $display("FAIL single_count got %0d want 1", out_count); n_fail++; end
        if (out_overflow !== 1'b0)  begin $display("FAIL single_ovf got %0b want 0", out_overflow); n_fail++; end
        if (in_ready !== 1'b0)      begin $display("FAIL single_in_ready got %0b want 0", in_ready); n_fail++; end
        take();
        if (out_valid !== 1'b0)     begin $display("FAIL single_drained_valid got %0b want 0", out_valid); n_fail++; end
        if (in_ready !== 1'b1)      begin $display("FAIL single_drained_in_ready got %0b want 1", in_ready); n_fail++; end
    endtask

    task automatic test_mixed_signs();
        send(1'b0, 3'd1, 9'h100, 1'b0);
        send(1'b1, 3'd0, 9'h003, 1'b1);
        n_tests += 4;
        if (out_valid !== 1'b1)     begin $display("FAIL mixed_valid got %0b want 1", out_valid); n_fail++; end
        if (out_sum !== 64'd65533)  begin $display("FAIL mixed_sum got %0d want 65533", out_sum); n_fail++; end
        if (out_count !== 4'd2)     begin $display("FAIL mixed_count got %0d want 2", out_count); n_fail++; end
        if (out_overflow !== 1'b0)  begin $display("FAIL mixed_ovf got %0b want 0", out_overflow); n_fail++; end
        take();
    endtask

    task automatic test_negative();
        send(1'b1, 3'd0, 9'h001, 1'b1);
        n_tests += 3;
        if (out_sum !== 64'hFFFF_FFFF_FFFF_FFFF) begin $display("FAIL neg_sum got %0h want ffffffffffffffff", out_sum); n_fail++; end
        if (out_overflow !== 1'b0)  begin $display("FAIL neg_ovf got %0b want 0", out_overflow); n_fail++; end
        take();
        send(1'b0, 3'd2, 9'h001, 1'b1);
        if (out_sum !== 64'd65536)  begin $display("FAIL cleared_sum got %0d want 65536", out_sum); n_fail++; end
        take();
    endtask

    task automatic test_backpressure();
        int bad_vld, bad_sum, bad_rdy;
        send(1'b0, 3'd0, 9'h007, 1'b1);
        bad_vld = 0; bad_sum = 0; bad_rdy = 0;
        in_valid = 1'b1; in_sign = 1'b0; in_seg = 3'd0; in_pattern = 9'h1FF; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1)   bad_vld++;
            if (out_sum !== 64'd7)    bad_sum++;
            if (in_ready !== 1'b0)    bad_rdy++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        n_tests += 7;
        if (bad_vld != 0) begin $display("FAIL bp_valid_stable cycles_bad=%0d want 0", bad_vld); n_fail++; end
        if (bad_sum != 0) begin $display("FAIL bp_sum_stable cycles_bad=%0d want 0", bad_sum); n_fail++; end
        if (bad_rdy != 0) begin $display("FAIL bp_in_ready_low cycles_bad=%0d want 0", bad_rdy); n_fail++; end
        take();
        if (out_valid !== 1'b0) begin $display("FAIL bp_valid_drop got %0b want 0", out_valid); n_fail++; end
        if (in_ready !== 1'b1)  begin $display("FAIL bp_in_ready_back got %0b want 1", in_ready); n_fail++; end
        send(1'b0, 3'd0, 9'h002, 1'b1);
        if (out_sum !== 64'd2)  begin $display("FAIL bp_next_sum got %0d want 2", out_sum); n_fail++; end
        if (out_count !== 4'd1) begin $display("FAIL bp_next_count got %0d want 1", out_count); n_fail++; end
        take();
    endtask

    task automatic test_overflow();
        send(1'b0, 3'd7, 9'h100, 1'b1);
        n_tests += 6;
        if (out_sum !== 64'd0)      begin $display("FAIL trunc_sum got %0h want 0", out_sum); n_fail++; end
        if (out_overflow !== 1'b1)  begin $display("FAIL trunc_ovf got %0b want 1", out_overflow); n_fail++; end
        take();
        send(1'b0, 3'd0, 9'h001, 1'b1);
        if (out_overflow !== 1'b0)  begin $display("FAIL ovf_cleared got %0b want 0", out_overflow); n_fail++; end
        if (out_sum !== 64'd1)      begin $display("FAIL ovf_next_sum got %0d want 1", out_sum); n_fail++; end
        take();
        // 2^62 + 2^62 = 2^63 does not fit in a signed 64-bit value.
        send(1'b0, 3'd7, 9'h040, 1'b0);
        send(1'b0, 3'd7, 9'h040, 1'b1);
        if (out_sum !== 64'h8000_0000_0000_0000) begin $display("FAIL sgn_ovf_sum got %0h want 8000000000000000", out_sum); n_fail++; end
        if (out_overflow !== 1'b1)  begin $display("FAIL sgn_ovf_flag got %0b want 1", out_overflow); n_fail++; end
        take();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 16; i++) send(1'b0, 3'd0, 9'h001, 1'b0);
        send(1'b0, 3'd0, 9'h001, 1'b1);
        n_tests += 2;
        if (out_count !== 4'd15) begin $display("FAIL sat_count got %0d want 15", out_count); n_fail++; end
        if (out_sum !== 64'd17)  begin $display("FAIL sat_sum got %0d want 17", out_sum); n_fail++; end
        take();
    endtask

    task automatic test_reset_mid();
        send(1'b0, 3'd0, 9'h011, 1'b0);
        send(1'b0, 3'd1, 9'h022, 1'b0);
        send(1'b1, 3'd0, 9'h033, 1'b0);
        #3 rst_n = 1'b0;
        #2;
        n_tests += 6;
        if (out_valid !== 1'b0) begin $display("FAIL rstmid_valid got %0b want 0", out_valid); n_fail++; end
        if (in_ready !== 1'b1)  begin $display("FAIL rstmid_in_ready got %0b want 1", in_ready); n_fail++; end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send(1'b0, 3'd0, 9'h005, 1'b1);
        if (out_sum !== 64'd5)  begin $display("FAIL rstmid_sum got %0d want 5", out_sum); n_fail++; end
        if (out_count !== 4'd1) begin $display("FAIL rstmid_count got %0d want 1", out_count); n_fail++; end
        // Reset while a result is pending drops that result.
        #3 rst_n = 1'b0;
        #2;
        if (out_valid !== 1'b0) begin $display("FAIL rstdrain_valid got %0b want 0", out_valid); n_fail++; end
        if (in_ready !== 1'b1)  begin $display("FAIL rstdrain_in_ready got %0b want 1", in_ready); n_fail++; end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_seg = '0;
        in_pattern = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_mixed_signs();
        test_negative();
        test_backpressure();
        test_overflow();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/signed_shift_accum.md
Name: signed_shift_accum

Overview:
- Downstream consumer of the signed shift LUT stage.
- Takes the LUT's 9-bit shifted magnitude pattern, plus sign and coarse segment index delayed 1 cycle upstream to align with the registered LUT output.
- Adds or subtracts the pattern into a wide two's-complement accumulator at position seg*SEG_STEP; emits the group sum on a `last`-terminated valid/ready output.
- Forms the accumulation back end of the POF dot-product datapath.

Parameters:
- ACC_W, 72: accumulator/result width, two's complement; must be >= SEG_STEP+9.
- SEG_W, 3: width of the segment index.
- SEG_STEP, 8: bit positions per segment unit.
- CNT_W, 16: term counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input term valid.
- in_ready  out  1  block can accept a term.
- in_sign  in  1  1 = subtract term, 0 = add term.
- in_seg  in  SEG_W  coarse shift; term offset = in_seg*SEG_STEP.
- in_pattern  in  9  unsigned magnitude from LUT stage.
- in_last  in  1  final term of the group.
- out_valid  out  1  group result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  ACC_W  signed group sum.
- out_count  out  CNT_W  terms in the group, saturating.
- out_overflow  out  1  sticky: signed overflow or truncated term bits in the group.

Behaviour:
- Reset (async, rst_n low):
  - State EMPTY; acc=0, cnt=0, ovf=0.
  - out_valid=0, out_sum=0, out_count=0, out_overflow=0.
  - in_ready=1 once in EMPTY.
- States:
  - EMPTY: no terms yet.
  - ACCUM: at least one term accepted.
  - DRAIN: result held for output.
- in_ready=1 in EMPTY and ACCUM, 0 in DRAIN. Decoded from state only; no combinational path from out_ready.
- Accept = in_valid & in_ready.
- Term formation:
  - term = zero-extended in_pattern << (in_seg*SEG_STEP), truncated to ACC_W.
  - Any set pattern bit landing at position >= ACC_W sets the overflow flag.
  - Bit ACC_W-1 of a term is not special. Overflow is judged on the signed add/sub result.
- Accumulate:
  - acc_next = acc + term (in_sign=0) or acc - term (in_sign=1), mod 2^ACC_W.
  - Signed overflow (operands' sign rule on the add/sub) ORs into ovf.
- Counter: cnt_next = cnt+1, saturating at 2^CNT_W-1 (no wrap).
- On accept with in_last=0:
  - acc <= acc_next; cnt and ovf updated; state -> ACCUM.
- On accept with in_last=1:
  - out_sum <= acc_next; out_count <= cnt_next; out_overflow <= ovf | this term's overflow.
  - out_valid <= 1; acc, cnt, ovf cleared; state -> DRAIN.
  - Latency: out_valid rises the cycle after the last term is accepted.
- DRAIN:
  - out_* held stable while out_valid & !out_ready.
  - On out_ready: out_valid <= 0, state -> EMPTY. in_ready is 1 the following cycle.
  - One dead input cycle per group, by design.
- Single-term group (first term with in_last=1) goes EMPTY -> DRAIN directly.
- in_valid with in_ready=0: input ignored. Upstream holds data stable (standard valid/ready).
- Async reset mid-group or mid-DRAIN drops partial sum and pending result; no output for that group.
- out_sum, out_count and out_overflow are registered. Their values are meaningful only while out_valid=1. They retain the last result after the handshake.

Test Plan:
- Single term: sign=0, seg=0, pattern=0x010, last=1 -> next cycle out_valid=1, out_sum=16, out_count=1, out_overflow=0; in_ready=0 until out_ready.
- Mixed signs: (+, seg=1, 0x100), (-, seg=0, 0x003, last) -> out_sum=65533, out_count=2, overflow=0.
- Negative result: (-, seg=0, 0x001, last) -> out_sum = all ones (-1); then (+, seg=2, 0x001, last) -> out_sum=65536, proving acc cleared between groups.
- Backpressure: out_ready=0 for 5 cycles after result -> out_valid and out_sum stable, in_ready=0, in_valid ignored; out_ready=1 -> out_valid drops next cycle; new term accepted the cycle after.
- Overflow, ACC_W=64: (+, seg=7, 0x100, last) -> bit 64 truncated, out_sum=0, out_overflow=1. Next group (+, seg=0, 0x001, last) -> out_overflow=0.
- Reset mid-group: accept 3 terms, pulse rst_n low asynchronously (mid-cycle) -> out_valid=0, in_ready=1. Next group (+, seg=0, 0x005, last) -> out_sum=5, out_count=1.
